// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder: valid/ready word intake with a one-word holding
// register so back-to-back words shift out on sout with no idle gap.
module bit_serializer #(
    parameter int unsigned W         = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    output logic         din_ready,
    input  logic         en,
    output logic         sout,
    output logic         sout_valid,
    output logic         idle
);

    localparam int unsigned CW = $clog2(W + 1);

    logic [W-1:0]  hold_reg;
    logic [W-1:0]  hold_reg_nxt;
    logic          hold_full;
    logic          hold_full_nxt;
    logic [W-1:0]  shreg;
    logic [W-1:0]  shreg_nxt;
    logic [CW-1:0] bit_cnt;
    logic [CW-1:0] bit_cnt_nxt;
    logic          accept;
    logic          last;
    logic          bypass;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_reg  <= '0;
            hold_full <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
        end else begin
            hold_reg  <= hold_reg_nxt;
            hold_full <= hold_full_nxt;
            shreg     <= shreg_nxt;
            bit_cnt   <= bit_cnt_nxt;
        end
    end

    // Next-state: shift, reload from hold or bypass from din, else park in hold
    always_comb begin
        hold_reg_nxt  = hold_reg;
        hold_full_nxt = hold_full;
        shreg_nxt     = shreg;
        bit_cnt_nxt   = bit_cnt;
        bypass        = 1'b0;
        accept        = din_valid && !hold_full;
        last          = (bit_cnt <= CW'(1));

        if (en) begin
            if (!last) begin
                shreg_nxt   = MSB_FIRST ? {shreg[W-2:0], 1'b0} : {1'b0, shreg[W-1:1]};
                bit_cnt_nxt = bit_cnt - CW'(1);
            end else if (hold_full) begin
                shreg_nxt     = hold_reg;
                bit_cnt_nxt   = CW'(W);
                hold_full_nxt = 1'b0;
            end else if (accept) begin
                shreg_nxt   = din;
                bit_cnt_nxt = CW'(W);
                bypass      = 1'b1;
            end else begin
                bit_cnt_nxt = '0;
            end
        end

        if (accept && !bypass) begin
            hold_reg_nxt  = din;
            hold_full_nxt = 1'b1;
        end
    end

    // Outputs decode directly from registers so reset clears them without a clock
    assign din_ready  = !hold_full;
    assign sout_valid = (bit_cnt != '0);
    assign sout       = sout_valid && (MSB_FIRST ? shreg[W-1] : shreg[0]);
    assign idle       = (bit_cnt == '0) && !hold_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: MSB-first and LSB-first instances share stimulus and
// are checked every cycle against a bit-queue reference model.
module tb_bit_serializer;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [W-1:0] din;
    logic         din_valid;
    logic         en;
    logic         a_din_ready, a_sout, a_sout_valid, a_idle;
    logic         b_din_ready, b_sout, b_sout_valid, b_idle;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining bits of the current word in output order, plus held words
    logic         bq_m[$];
    logic         bq_l[$];
    logic [W-1:0] held[$];

    // Observed history for directed scenarios
    logic cap_m[$];
    logic cap_l[$];
    logic vq[$];
    int   nready0;

    always #5 clk = ~clk;

    bit_serializer #(.W(W), .MSB_FIRST(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .din_ready(a_din_ready), .en(en), .sout(a_sout),
        .sout_valid(a_sout_valid), .idle(a_idle)
    );

    bit_serializer #(.W(W), .MSB_FIRST(1'b0)) dut_b (
        .clk(clk), .reset_n(reset_n), .din(din), .din_valid(din_valid),
        .din_ready(b_din_ready), .en(en), .sout(b_sout),
        .sout_valid(b_sout_valid), .idle(b_idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_load(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) bq_m.push_back(w[i]);
        for (int i = 0; i < int'(W); i++) bq_l.push_back(w[i]);
    endtask

    task automatic model_clear();
        bq_m.delete();
        bq_l.delete();
        held.delete();
    endtask

    // One rising edge of the model using the inputs currently applied
    task automatic model_edge();
        logic acc;
        logic byp;
        acc = din_valid && (held.size() == 0);
        byp = 1'b0;
        if (en) begin
            if (bq_m.size() > 1) begin
                void'(bq_m.pop_front());
                void'(bq_l.pop_front());
            end else begin
                bq_m.delete();
                bq_l.delete();
                if (held.size() != 0) begin
                    model_load(held.pop_front());
                end else if (acc) begin
                    model_load(din);
                    byp = 1'b1;
                end
            end
        end
        if (acc && !byp) held.push_back(din);
    endtask

    task automatic chk_outputs();
        logic busy;
        logic rdy;
        busy = (bq_m.size() != 0);
        rdy  = (held.size() == 0);
        chk("a_din_ready",  32'(a_din_ready),  32'(rdy));
        chk("a_sout_valid", 32'(a_sout_valid), 32'(busy));
        chk("a_sout",       32'(a_sout),       32'(busy ? bq_m[0] : 1'b0));
        chk("a_idle",       32'(a_idle),       32'(!busy && rdy));
        chk("b_din_ready",  32'(b_din_ready),  32'(rdy));
        chk("b_sout_valid", 32'(b_sout_valid), 32'(busy));
        chk("b_sout",       32'(b_sout),       32'(busy ? bq_l[0] : 1'b0));
        chk("b_idle",       32'(b_idle),       32'(!busy && rdy));
    endtask

    // Called at a negedge with inputs applied; returns at the next negedge
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk_outputs();
        if (a_sout_valid) cap_m.push_back(a_sout);
        if (b_sout_valid) cap_l.push_back(b_sout);
        vq.push_back(a_sout_valid);
        if (!a_din_ready) nready0++;
        @(negedge clk);
    endtask

    task automatic run_until_idle();
        for (int i = 0; i < 40 && !a_idle; i++) tick();
        chk("idle_reached", 32'(a_idle), 32'd1);
    endtask

    task automatic clear_capture();
        cap_m.delete();
        cap_l.delete();
        vq.delete();
        nready0 = 0;
    endtask

    function automatic logic [31:0] pack(input logic q[$]);
        logic [31:0] v = '0;
        foreach (q[i]) v = {v[30:0], q[i]};
        return v;
    endfunction

    function automatic int gaps(input logic q[$]);
        int first = -1;
        int lst = -1;
        int n = 0;
        foreach (q[i]) if (q[i]) begin
            if (first < 0) first = i;
            lst = i;
        end
        for (int i = first + 1; i < lst; i++) if (!q[i]) n++;
        return n;
    endfunction

    task automatic send(input logic [W-1:0] w);
        din       = w;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        en        = 1'b1;
        model_clear();
        clear_capture();
        #2;
        chk_outputs();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;

        // Single word, MSB-first 8'hE5
        clear_capture();
        send(8'hE5);
        run_until_idle();
        chk("e5_len",  32'(cap_m.size()), 32'd8);
        chk("e5_bits", pack(cap_m), 32'h0000_00E5);
        chk("e5_lsb",  pack(cap_l), 32'h0000_00A7);

        // Back-to-back 8'hE8, 8'hC4 with din_valid held
        clear_capture();
        din       = 8'hE8;
        din_valid = 1'b1;
        tick();
        din = 8'hC4;
        tick();
        din_valid = 1'b0;
        run_until_idle();
        chk("b2b_len",    32'(cap_m.size()), 32'd16);
        chk("b2b_bits",   pack(cap_m), 32'h0000_E8C4);
        chk("b2b_gaps",   32'(gaps(vq)), 32'd0);
        chk("b2b_ready0", 32'(nready0), 32'd7);

        // Enable stall for 3 cycles after the 2nd bit of 8'hA5
        clear_capture();
        send(8'hA5);
        tick();
        en = 1'b0;
        repeat (3) tick();
        en = 1'b1;
        run_until_idle();
        chk("stall_len",  32'(cap_m.size()), 32'd11);
        chk("stall_bits", pack(cap_m), 32'b100_0010_0101);

        // 8'h01 then 8'h80: LSB-first instance gives 1,0x7,0x7,1
        clear_capture();
        send(8'h01);
        send(8'h80);
        run_until_idle();
        chk("lsb_bits", pack(cap_l), 32'h0000_8001);
        chk("msb_bits", pack(cap_m), 32'h0000_0180);

        // Late feed on the bit_cnt==1 cycle: bypass, no gap
        clear_capture();
        send(8'h3C);
        repeat (7) tick();
        send(8'h5A);
        run_until_idle();
        chk("late0_gaps", 32'(gaps(vq)), 32'd0);
        chk("late0_bits", pack(cap_m), 32'h0000_3C5A);

        // One cycle later: exactly one empty cycle between words
        clear_capture();
        send(8'h3C);
        repeat (8) tick();
        send(8'h5A);
        run_until_idle();
        chk("late1_gaps", 32'(gaps(vq)), 32'd1);
        chk("late1_bits", pack(cap_m), 32'h0000_3C5A);

        // Async reset 3 bits into 8'hE8, with a word parked in hold
        send(8'hE8);
        din       = 8'h77;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        #2;
        reset_n = 1'b0;
        #1;
        model_clear();
        chk_outputs();
        chk("rst_ready", 32'(a_din_ready), 32'd1);
        chk("rst_idle",  32'(a_idle), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        chk_outputs();

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            din       = W'($urandom);
            din_valid = 1'($urandom_range(0, 1));
            en        = ($urandom_range(0, 3) != 0);
            tick();
        end
        din_valid = 1'b0;
        en        = 1'b1;
        run_until_idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_serializer.md
# bit_serializer

Upstream feeder for the even/odd consecutive-zero detector FSM. It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock on `sout`, which drives the detector's `x` input. A one-word holding register lets back-to-back words stream with no idle gap between them. `sout_valid` and `idle` tell downstream logic when the bit stream is meaningful.

## Interface
- `W`, default 8: word width, ≥ 2.
- `MSB_FIRST`, default 1: 1 = bit W-1 is shifted out first; 0 = bit 0 is shifted out first.

- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset. Clears all state immediately.
- `din`  in  W  parallel word.
- `din_valid`  in  1  `din` is valid this cycle.
- `din_ready`  out  1  the block can accept a word. Equals `!hold_full` (combinational from a register).
- `en`  in  1  shift enable. When 0, shifter state is frozen.
- `sout`  out  1  serial bit. Driven 0 when `sout_valid`=0.
- `sout_valid`  out  1  `sout` carries a data bit (`bit_cnt != 0`).
- `idle`  out  1  shifter empty and holding register empty.

## Operation
- **State registers:**
  - `hold_reg[W-1:0]`, `hold_full`
  - `shreg[W-1:0]`
  - `bit_cnt` in 0..W (0 = shifter empty). Width is `$clog2(W+1)`.
- **Reset values:** all registers 0. Therefore `din_ready`=1, `sout`=0, `sout_valid`=0, `idle`=1.
- **Accept:** a word is accepted when `din_valid && din_ready` at a rising edge.
- **`sout`:**
  - MSB_FIRST=1: `shreg[W-1]`; MSB_FIRST=0: `shreg[0]`.
  - Gated to 0 when `bit_cnt`=0.
- **Per-edge update when `en`=1. Let `last` = (`bit_cnt` ≤ 1):**
  - `bit_cnt` > 1: shift `shreg` by one toward the output end (zero-fill), `bit_cnt` -= 1.
  - `last` and `hold_full`: load `shreg` from `hold_reg`, `bit_cnt`=W, `hold_full`=0.
  - `last`, `!hold_full`, and an accept this edge: bypass, load `shreg` from `din`, `bit_cnt`=W. The holding register stays empty.
  - `last`, nothing available: `bit_cnt`=0.
- **Accept that is not bypassed:** the accepted word goes to `hold_reg` and `hold_full`=1. This covers `bit_cnt` > 1, or `en`=0.
- **Accept and hold→shifter transfer on the same edge:** impossible by construction, since accept requires `hold_full`=0.
- **`en`=0:**
  - `shreg` and `bit_cnt` hold.
  - `sout` and `sout_valid` keep their values.
  - The holding register may still accept a word if empty.
- **Mid-operation reset:** async assertion clears the partial word and the held word immediately. Output returns to reset values with no clock edge. Deassertion is used synchronously to `clk` by the bench (negedge).
- **No backpressure from downstream:** one bit is consumed per enabled cycle.

## Timing
- **Latency:** a word accepted at edge k into an empty shifter has its first bit on `sout` after edge k. Bits occupy cycles k..k+W-1, with `sout_valid` high exactly W enabled cycles.
- **Gapless streaming:** the next word must either be in `hold_reg`, or be accepted on the edge where `bit_cnt`=1. The first bit of word n+1 then follows the last bit of word n in the next cycle.
- **`din_ready` with `din_valid` held high continuously:**
  - `din_ready` is 1 for word 1 (bypass) and 1 on the following edge (word 2 into hold).
  - It is then 0 until the hold→shifter transfer, and 1 again from the cycle after.
- **`idle`:** rises the cycle after the last bit, provided nothing is held.
- **`en` low:** stretches every count above by the number of disabled cycles.

## Test plan
- **Reset:** assert `reset_n`=0 mid-stream (for example, 3 bits into 8'hE8). Require the outputs to go to `sout`=0, `sout_valid`=0, `idle`=1, `din_ready`=1 without waiting for a clock edge.
- **Single word:** W=8, MSB_FIRST=1. Send 8'hE5 into an idle block. Require `sout` = 1,1,1,0,0,1,0,1 on 8 consecutive cycles, `sout_valid` high exactly those 8 cycles, then `idle`=1.
- **Back-to-back detector stimulus:** send 8'hE8 then 8'hC4 with `din_valid` held.
  - Require 16 contiguous valid bits: 1,1,1,0,1,0,0,0,1,1,0,0,0,1,0,0.
  - Require `din_ready`=0 from the cycle after the second accept until the hold→shifter transfer.
- **Enable stall:** send 8'hA5. Drop `en` for 3 cycles after the 2nd bit. Require `sout` to hold at 0 (bit 2 of 1010_0101) for those cycles, then continue 1,0,0,1,0,1, with 11 valid cycles total.
- **LSB-first:** MSB_FIRST=0. Send 8'h01, then 8'h80. Require 1 followed by seven 0s, then seven 0s followed by 1.
- **Late feed:** present the second word only when `bit_cnt`=1 (bypass path). Require no gap between words. Present it one cycle later and require exactly one cycle with `sout_valid`=0 and `sout`=0.
